// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM with clear engine.
// Parity storage is enabled by defining RAM_PARITY_EN.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int unsigned RD_LATENCY   = 1;
    localparam int unsigned PARITY_MAX_W = 64;

    // Even parity; callers zero-extend, which leaves the result unchanged.
    function automatic logic parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage array: one write port and a registered read port with valid pulse.
// With RAM_PARITY_EN defined each word carries an extra even-parity bit.
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              inject_err,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] write_word;
    logic [WORD_W-1:0] read_word;
    logic              read_perr;

`ifdef RAM_PARITY_EN
    assign write_word = {parity(PARITY_MAX_W'(write_data)) ^ inject_err, write_data};
    assign read_perr  = read_word[DATA_W] != parity(PARITY_MAX_W'(read_word[DATA_W-1:0]));
`else
    logic unused_inject_err;
    assign unused_inject_err = inject_err;
    assign write_word        = write_data;
    assign read_perr         = 1'b0;
`endif

    assign read_word = mem[addr];

    // Memory contents are never reset; the clear engine initialises them.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[addr] <= write_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en) begin
                read_data  <= read_word[DATA_W-1:0];
                parity_err <= read_perr;
            end
        end
    end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with valid/ready requests, 1-cycle reads and a clear engine.
// Optional parity storage and checking under RAM_PARITY_EN.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       ADDR_W   = 3,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_clear,
    input  logic              i_inject_err,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_read_valid,
    output logic              o_busy,
    output logic              o_parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              clearing;
    logic              accept;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_inject;

    assign o_ready = (state == IDLE);
    assign o_busy  = (state == CLEAR);

    // Nothing touches the array while reset is held.
    assign clearing = (state == CLEAR) && i_rst_n;
    assign accept   = i_req && (state == IDLE) && i_rst_n;

    assign arr_we     = clearing || (accept && i_write_en);
    assign arr_re     = accept && !i_write_en;
    assign arr_addr   = clearing ? clr_addr : i_addr;
    assign arr_wdata  = clearing ? INIT_VAL : i_write_data;
    assign arr_inject = !clearing && i_inject_err;

    // Clear engine walks every address once, then hands over to IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (i_clear) begin
                        state <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .write_en   (arr_we),
        .read_en    (arr_re),
        .addr       (arr_addr),
        .write_data (arr_wdata),
        .inject_err (arr_inject),
        .read_data  (o_read_data),
        .read_valid (o_read_valid),
        .parity_err (o_parity_err)
    );

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed self-checking bench for ram_sp_clr (DATA_W=4, ADDR_W=3, INIT_VAL=0).
module tb_ram_sp_clr;
    import ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       ready;
    logic       write_en;
    logic [2:0] addr;
    logic [3:0] write_data;
    logic       clear;
    logic       inject_err;
    logic [3:0] read_data;
    logic       read_valid;
    logic       busy;
    logic       parity_err;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    ram_sp_clr dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .o_ready      (ready),
        .i_write_en   (write_en),
        .i_addr       (addr),
        .i_write_data (write_data),
        .i_clear      (clear),
        .i_inject_err (inject_err),
        .o_read_data  (read_data),
        .o_read_valid (read_valid),
        .o_busy       (busy),
        .o_parity_err (parity_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with busy high, bounded so a stuck engine cannot hang the run.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d, input logic inj);
        req = 1'b1; write_en = 1'b1; addr = a; write_data = d; inject_err = inj;
        tick();
        req = 1'b0; write_en = 1'b0; inject_err = 1'b0;
        check("write_no_valid", 32'(read_valid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [2:0] a, input logic [3:0] exp);
        req = 1'b1; write_en = 1'b0; addr = a;
        tick();
        req = 1'b0;
        check({tag, "_valid"}, 32'(read_valid), 32'd1);
        check({tag, "_data"}, 32'(read_data), 32'(exp));
    endtask

    logic [3:0] pattern [8];

    initial begin
        pattern[0] = 4'h7; pattern[1] = 4'hD; pattern[2] = 4'hA; pattern[3] = 4'h6;
        pattern[4] = 4'h9; pattern[5] = 4'h3; pattern[6] = 4'hC; pattern[7] = 4'h5;

        rst_n = 1'b0; req = 1'b0; write_en = 1'b0; addr = '0; write_data = '0;
        clear = 1'b0; inject_err = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_data", 32'(read_data), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);

        // 1: initial clear takes DEPTH cycles, memory reads INIT_VAL.
        rst_n = 1'b1;
        wait_busy(n);
        check("init_busy_cycles", 32'(n), 32'd8);
        check("init_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 8; i++) do_read("init_rd", 3'(i), 4'h0);

        // 2: write pattern, read back with latency RD_LATENCY.
        for (int i = 0; i < 8; i++) do_write(3'(i), pattern[i], 1'b0);
        for (int i = 0; i < 8; i++) do_read("pat_rd", 3'(i), pattern[i]);
        check("rd_latency_const", 32'(RD_LATENCY), 32'd1);

        // 3: back-to-back reads give consecutive valid pulses; data holds after.
        req = 1'b1; write_en = 1'b0; addr = 3'd3;
        tick();
        check("b2b0_valid", 32'(read_valid), 32'd1);
        check("b2b0_data", 32'(read_data), 32'h6);
        addr = 3'd4;
        tick();
        check("b2b1_valid", 32'(read_valid), 32'd1);
        check("b2b1_data", 32'(read_data), 32'h9);
        addr = 3'd5;
        tick();
        req = 1'b0;
        check("b2b2_valid", 32'(read_valid), 32'd1);
        check("b2b2_data", 32'(read_data), 32'h3);
        tick();
        check("b2b_end_valid", 32'(read_valid), 32'd0);
        check("hold_data", 32'(read_data), 32'h3);

        // 4: read-after-write, then a read issued together with clear.
        do_write(3'd2, 4'hE, 1'b0);
        do_read("raw_e", 3'd2, 4'hE);
        do_write(3'd2, 4'hA, 1'b0);
        req = 1'b1; write_en = 1'b0; addr = 3'd2; clear = 1'b1;
        tick();
        req = 1'b0; clear = 1'b0;
        check("clr_rd_valid", 32'(read_valid), 32'd1);
        check("clr_rd_data", 32'(read_data), 32'hA);
        check("clr_started", 32'(busy), 32'd1);
        wait_busy(n);
        check("clr_busy_cycles", 32'(n), 32'd8);
        do_read("post_clr2", 3'd2, 4'h0);
        do_read("post_clr7", 3'd7, 4'h0);

        // Write accepted with clear is overwritten by the clear.
        req = 1'b1; write_en = 1'b1; addr = 3'd3; write_data = 4'hF; clear = 1'b1;
        tick();
        req = 1'b0; write_en = 1'b0; clear = 1'b0;
        check("clr_wr_no_valid", 32'(read_valid), 32'd0);
        wait_busy(n);
        check("clr_wr_busy_cycles", 32'(n), 32'd8);
        do_read("clr_wr_rd3", 3'd3, 4'h0);

        // 5: reset during the 4th clear cycle restarts the engine.
        do_write(3'd4, 4'h9, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        tick();
        check("mid_clr_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; req = 1'b1; write_en = 1'b0; addr = 3'd4;
        tick();
        rst_n = 1'b1;
        check("rst_restart_busy", 32'(busy), 32'd1);
        check("rst_restart_valid", 32'(read_valid), 32'd0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
            check("restart_no_valid", 32'(read_valid), 32'd0);
        end
        req = 1'b0;
        check("restart_busy_cycles", 32'(n), 32'd8);
        do_read("restart_rd4", 3'd4, 4'h0);

        // 6: parity injection and recovery.
        do_write(3'd6, 4'hF, 1'b1);
        do_read("perr_inj", 3'd6, 4'hF);
`ifdef RAM_PARITY_EN
        check("perr_set", 32'(parity_err), 32'd1);
`else
        check("perr_tied0", 32'(parity_err), 32'd0);
`endif
        do_write(3'd6, 4'hF, 1'b0);
        do_read("perr_clean", 3'd6, 4'hF);
        check("perr_clear", 32'(parity_err), 32'd0);
        do_write(3'd1, 4'h7, 1'b0);
        do_read("perr_odd", 3'd1, 4'h7);
        check("perr_odd_clear", 32'(parity_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
